// File: rtl/apb_cfg_master.sv
// APB requester for the memory arbiter configuration port.
// Runs one outstanding SETUP/ACCESS transfer per command, with an ACCESS timeout and error counter.
module apb_cfg_master #(
    parameter int unsigned TIMEOUT_P   = 16,
    parameter int unsigned ERR_CNT_W_P = 16
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_wr,
    input  logic [31:0]            cmd_addr,
    input  logic [31:0]            cmd_wdata,
    input  logic [3:0]             cmd_strb,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_rdata,
    output logic                   rsp_slverr,
    output logic                   rsp_timeout,

    output logic                   conf_sel,
    output logic                   conf_enable,
    output logic                   conf_wr,
    output logic [31:0]            conf_addr,
    output logic [31:0]            conf_wdata,
    output logic [3:0]             conf_strb,
    input  logic [31:0]            conf_rdata,
    input  logic                   conf_ready,
    input  logic                   conf_slverr,

    output logic                   busy,
    output logic [ERR_CNT_W_P-1:0] err_count
);

    localparam int unsigned TcW = (TIMEOUT_P == 0) ? 1 : $clog2(TIMEOUT_P + 1);
    localparam logic [TcW-1:0] TcLast = TcW'((TIMEOUT_P == 0) ? 0 : TIMEOUT_P - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                 state_q, state_d;
    logic                   conf_wr_q, conf_wr_d;
    logic [31:0]            conf_addr_q, conf_addr_d;
    logic [31:0]            conf_wdata_q, conf_wdata_d;
    logic [3:0]             conf_strb_q, conf_strb_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_slverr_q, rsp_slverr_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [ERR_CNT_W_P-1:0] err_cnt_q, err_cnt_d;
    logic [TcW-1:0]         tcnt_q, tcnt_d;
    logic                   err_inc;
    logic                   timeout_hit;

    assign timeout_hit = (TIMEOUT_P != 0) && (tcnt_q == TcLast);

    always_comb begin
        state_d       = state_q;
        conf_wr_d     = conf_wr_q;
        conf_addr_d   = conf_addr_q;
        conf_wdata_d  = conf_wdata_q;
        conf_strb_d   = conf_strb_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;
        tcnt_d        = tcnt_q;
        err_inc       = 1'b0;

        case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    conf_wr_d    = cmd_wr;
                    conf_addr_d  = cmd_addr;
                    conf_wdata_d = cmd_wdata;
                    conf_strb_d  = cmd_wr ? cmd_strb : 4'h0;
                    state_d      = StSetup;
                end
            end
            StSetup: begin
                tcnt_d  = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (conf_ready) begin
                    rsp_rdata_d   = conf_wr_q ? 32'h0 : conf_rdata;
                    rsp_slverr_d  = conf_slverr;
                    rsp_timeout_d = 1'b0;
                    err_inc       = conf_slverr;
                    state_d       = StResp;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = 32'h0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    err_inc       = 1'b1;
                    state_d       = StResp;
                end else if (tcnt_q != '1) begin
                    // Saturate so a disabled timeout never wraps into a false hit.
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = (err_inc && (err_cnt_q != '1)) ? err_cnt_q + 1'b1 : err_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            conf_wr_q     <= 1'b0;
            conf_addr_q   <= 32'h0;
            conf_wdata_q  <= 32'h0;
            conf_strb_q   <= 4'h0;
            rsp_rdata_q   <= 32'h0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
            err_cnt_q     <= '0;
            tcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            conf_wr_q     <= conf_wr_d;
            conf_addr_q   <= conf_addr_d;
            conf_wdata_q  <= conf_wdata_d;
            conf_strb_q   <= conf_strb_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
            err_cnt_q     <= err_cnt_d;
            tcnt_q        <= tcnt_d;
        end
    end

    // Handshake and phase outputs decode straight from the state register.
    assign cmd_ready   = (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign conf_sel    = (state_q == StSetup) || (state_q == StAccess);
    assign conf_enable = (state_q == StAccess);

    assign conf_wr     = conf_wr_q;
    assign conf_addr   = conf_addr_q;
    assign conf_wdata  = conf_wdata_q;
    assign conf_strb   = conf_strb_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_slverr  = rsp_slverr_q;
    assign rsp_timeout = rsp_timeout_q;
    assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// Scoreboard bench for apb_cfg_master: directed commands push expected responses,
// a monitor pops and compares on every response handshake.
module tb_apb_cfg_master;

    localparam int unsigned TimeoutP = 16;
    localparam int unsigned ErrW     = 2;

    typedef struct {
        logic [31:0]     rdata;
        logic            slverr;
        logic            timeout;
        logic [ErrW-1:0] errc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic            cmd_wr = 1'b0;
    logic [31:0]     cmd_addr = 32'h0;
    logic [31:0]     cmd_wdata = 32'h0;
    logic [3:0]      cmd_strb = 4'h0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [31:0]     rsp_rdata;
    logic            rsp_slverr;
    logic            rsp_timeout;
    logic            conf_sel;
    logic            conf_enable;
    logic            conf_wr;
    logic [31:0]     conf_addr;
    logic [31:0]     conf_wdata;
    logic [3:0]      conf_strb;
    logic [31:0]     conf_rdata = 32'h0;
    logic            conf_ready = 1'b0;
    logic            conf_slverr = 1'b0;
    logic            busy;
    logic [ErrW-1:0] err_count;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    // Completer model
    logic cpl_hang = 1'b0;
    int   cpl_wait = 0;
    int   acc_cnt = 0;
    int   last_acc_len = 0;

    always #5 clk = ~clk;

    apb_cfg_master #(
        .TIMEOUT_P  (TimeoutP),
        .ERR_CNT_W_P(ErrW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .rsp_timeout(rsp_timeout),
        .conf_sel   (conf_sel),
        .conf_enable(conf_enable),
        .conf_wr    (conf_wr),
        .conf_addr  (conf_addr),
        .conf_wdata (conf_wdata),
        .conf_strb  (conf_strb),
        .conf_rdata (conf_rdata),
        .conf_ready (conf_ready),
        .conf_slverr(conf_slverr),
        .busy       (busy),
        .err_count  (err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Ready after cpl_wait ACCESS cycles; records how long each ACCESS phase lasted.
    always @(negedge clk) begin
        if (conf_sel && conf_enable) begin
            conf_ready = !cpl_hang && (acc_cnt == cpl_wait);
            acc_cnt++;
        end else begin
            conf_ready = 1'b0;
            if (acc_cnt != 0) last_acc_len = acc_cnt;
            acc_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got response rdata=0x%08h with no command pending",
                         rsp_rdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_slverr", 32'(rsp_slverr), 32'(e.slverr));
                check("rsp_timeout", 32'(rsp_timeout), 32'(e.timeout));
                check("err_count", 32'(err_count), 32'(e.errc));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge (SETUP cycle).
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input exp_t e);
        int   n  = 0;
        logic ok = 1'b0;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_strb  = s;
        cmd_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        cmd_valid = 1'b0;
        if (ok) begin
            exp_q.push_back(e);
        end else begin
            tests++;
            fails++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (busy || exp_q.size() != 0) begin
            fails++;
            $display("FAIL wait_done: busy=%0b pending=%0d, required 0 and 0", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #1 rst = 1'b1;
        #2;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sel_en", 32'({conf_sel, conf_enable, conf_wr}), 32'd0);
        check("rst_conf_addr", conf_addr, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-wait write: SETUP cycle 1, ACCESS cycle 2, RESP cycle 3
        conf_rdata = 32'hDEAD_BEEF;
        cpl_wait   = 0;
        issue(1'b1, 32'h0, 32'hA5A5_0003, 4'hF, '{32'h0, 1'b0, 1'b0, 2'd0});
        @(negedge clk);
        check("wr_setup_sel_en", 32'({conf_sel, conf_enable}), 32'b10);
        check("wr_conf_wdata", conf_wdata, 32'hA5A5_0003);
        check("wr_conf_strb_wr", 32'({conf_strb, conf_wr}), 32'h1F);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wr_access_sel_en", 32'({conf_sel, conf_enable}), 32'b11);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("wr_rsp_valid_c3", 32'({rsp_valid, conf_sel}), 32'b10);
        wait_done();

        // Read with three wait states
        conf_rdata   = 32'h0403_0201;
        cpl_wait     = 3;
        last_acc_len = 0;
        issue(1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, '{32'h0403_0201, 1'b0, 1'b0, 2'd0});
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            if (conf_sel) begin
                check("rd_conf_addr", conf_addr, 32'h4);
                check("rd_conf_strb_wr", 32'({conf_strb, conf_wr}), 32'h0);
            end
            n++;
        end
        wait_done();
        check("rd_access_len", 32'(last_acc_len), 32'd4);

        // Completer hangs: timeout after TimeoutP ACCESS cycles
        cpl_hang     = 1'b1;
        last_acc_len = 0;
        issue(1'b0, 32'h8, 32'h0, 4'h0, '{32'h0, 1'b1, 1'b1, 2'd1});
        wait_done();
        check("to_access_len", 32'(last_acc_len), TimeoutP);
        cpl_hang = 1'b0;

        // Asynchronous reset in the middle of ACCESS
        cpl_hang = 1'b1;
        issue(1'b1, 32'h10, 32'h1234, 4'h3, '{32'h0, 1'b0, 1'b0, 2'd0});
        repeat (3) @(posedge clk);
        #3;
        check("mid_access_en", 32'(conf_enable), 32'd1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("arst_sel_en_wr", 32'({conf_sel, conf_enable, conf_wr}), 32'd0);
        check("arst_addr", conf_addr, 32'h0);
        check("arst_wdata", conf_wdata, 32'h0);
        check("arst_strb", 32'(conf_strb), 32'd0);
        check("arst_rsp", 32'({rsp_valid, rsp_slverr, rsp_timeout}), 32'd0);
        check("arst_rdata", rsp_rdata, 32'h0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_ready_busy", 32'({cmd_ready, busy}), 32'b10);
        @(posedge clk);
        #1 rst = 1'b0;
        cpl_hang = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        cpl_wait = 0;
        issue(1'b1, 32'h20, 32'h55, 4'hF, '{32'h0, 1'b0, 1'b0, 2'd0});
        wait_done();

        // Completer errors: counter saturates at 3
        conf_slverr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            e.rdata   = 32'h0;
            e.slverr  = 1'b1;
            e.timeout = 1'b0;
            e.errc    = (i >= 2) ? 2'd3 : ErrW'(i + 1);
            issue(1'b1, 32'h30, 32'(i), 4'hF, e);
            wait_done();
        end
        conf_slverr = 1'b0;
        check("err_sat", 32'(err_count), 32'd3);

        // Response backpressure with the next command already waiting
        conf_rdata = 32'h1122_3344;
        rsp_ready  = 1'b0;
        issue(1'b1, 32'h40, 32'h7, 4'hF, '{32'h0, 1'b0, 1'b0, 2'd3});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 20);
        check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                cmd_wr    = 1'b0;
                cmd_addr  = 32'h44;
                cmd_strb  = 4'hF;
                cmd_valid = 1'b1;
            end
            @(negedge clk);
            check("bp_hold_valid_ready_sel", 32'({rsp_valid, cmd_ready, conf_sel}), 32'b100);
            check("bp_hold_rdata", rsp_rdata, 32'h0);
            check("bp_hold_slverr", 32'(rsp_slverr), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back('{32'h1122_3344, 1'b0, 1'b0, 2'd3});
        @(negedge clk);
        check("bp_idle_ready_sel", 32'({cmd_ready, conf_sel}), 32'b10);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("bp_next_setup", 32'({conf_sel, conf_enable}), 32'b10);
        check("bp_next_addr", conf_addr, 32'h44);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
